// File: rtl/distribute_ingress_buffer.sv
// Purpose     : elastic {cmd, data} token FIFO feeding the 1x2 distribute switch (head token on o_*).
// Latency     : token pushed at edge N is presented on o_valid/o_data_bus/o_cmd after edge N; no bypass.
// Backpressure: o_ready = !o_full from registered count only; a pop never frees a slot for a same-cycle push.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_valid, i_data_bus, i_cmd      producer token (push = i_valid & o_ready)
//   o_ready                         buffer can accept a token this cycle
//   o_valid, o_data_bus, o_cmd      head token toward the switch (all-zero when empty)
//   i_en                            switch enable, doubles as pop (pop = o_valid & i_en)
//   o_count, o_full, o_empty        occupancy and its registered-count derived flags
//
// Build option: define DIST_INGRESS_DROP_NULL_EN to accept-and-discard tokens whose cmd is 00.
module distribute_ingress_buffer #(
   parameter int DATA_WIDTH    = 32,
   parameter int COMMAND_WIDTH = 2,
   parameter int DEPTH         = 4,
   localparam int CW           = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH-1:0]    i_data_bus,
   input  logic [COMMAND_WIDTH-1:0] i_cmd,
   output logic                     o_ready,
   output logic                     o_valid,
   output logic [DATA_WIDTH-1:0]    o_data_bus,
   output logic [COMMAND_WIDTH-1:0] o_cmd,
   input  logic                     i_en,
   output logic [CW-1:0]            o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [COMMAND_WIDTH-1:0] cmd;
      logic [DATA_WIDTH-1:0]    data;
   } token_t;

   token_t        mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;

   logic   push;
   logic   pop;
   logic   store;
   token_t head;

   assign o_full  = (count_q == CW'(DEPTH));
   assign o_empty = (count_q == '0);
   assign o_ready = !o_full;
   assign o_valid = !o_empty;
   assign o_count = count_q;

   assign push = i_valid & o_ready;
   assign pop  = o_valid & i_en;

`ifdef DIST_INGRESS_DROP_NULL_EN
   // Null-command tokens complete the handshake but never occupy a slot.
   assign store = push & (i_cmd != '0);
`else
   assign store = push;
`endif

   // Switch sees all-zero dummy data while nothing is buffered.
   always_comb begin
      head       = mem[rd_ptr];
      o_data_bus = '0;
      o_cmd      = '0;
      if (!o_empty) begin
         o_data_bus = head.data;
         o_cmd      = head.cmd;
      end
   end

   // Storage is deliberately not reset; valid/empty gate every read.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_ptr] <= '{cmd: i_cmd, data: i_data_bus};
      end
   end

   // Explicit wrap keeps non-power-of-two depths correct.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (store) begin
         if (wr_ptr == PW'(DEPTH - 1)) wr_ptr <= '0;
         else                          wr_ptr <= wr_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
      end else if (pop) begin
         if (rd_ptr == PW'(DEPTH - 1)) rd_ptr <= '0;
         else                          rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         case ({store, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
